// File: rtl/mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one memory port arbiter.
// One transaction in flight; round-robin on simultaneous requests.
module mem_arbiter #(
  parameter int DATA_LEN = 32,
  parameter int MASK_LEN = DATA_LEN / 8
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [DATA_LEN-1:0] ifu_req_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_LEN-1:0] ifu_rsp_rdata,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [DATA_LEN-1:0] lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_LEN-1:0] lsu_req_wdata,
  input  logic [MASK_LEN-1:0] lsu_req_wmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_LEN-1:0] lsu_rsp_rdata,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [DATA_LEN-1:0] mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_LEN-1:0] mem_req_wdata,
  output logic [MASK_LEN-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_LEN-1:0] mem_rsp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

  state_e state, state_nxt;
  owner_e owner, last_grant;
  logic   grant_ifu, grant_lsu;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_IFU;
      last_grant    <= OWN_IFU;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
    end else begin
      state <= state_nxt;
      if (grant_ifu || grant_lsu) begin
        owner         <= grant_lsu ? OWN_LSU : OWN_IFU;
        last_grant    <= grant_lsu ? OWN_LSU : OWN_IFU;
        mem_req_addr  <= grant_lsu ? lsu_req_addr : ifu_req_addr;
        mem_req_wen   <= grant_lsu & lsu_req_wen;
        mem_req_wdata <= grant_lsu ? lsu_req_wdata : '0;
        mem_req_wmask <= grant_lsu ? lsu_req_wmask : '0;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_ifu     = 1'b0;
    grant_lsu     = 1'b0;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    ifu_rsp_rdata = '0;
    lsu_rsp_rdata = '0;

    case (state)
      IDLE: begin
        // On a tie the master that did not win last time gets the port.
        if (ifu_req_valid && lsu_req_valid) begin
          grant_lsu = (last_grant == OWN_IFU);
          grant_ifu = (last_grant == OWN_LSU);
        end else begin
          grant_ifu = ifu_req_valid;
          grant_lsu = lsu_req_valid;
        end
        if (grant_ifu || grant_lsu) state_nxt = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = RSP;
      end
      RSP: begin
        if (owner == OWN_IFU) begin
          mem_rsp_ready = ifu_rsp_ready;
          ifu_rsp_valid = mem_rsp_valid;
          ifu_rsp_rdata = mem_rsp_valid ? mem_rsp_rdata : '0;
        end else begin
          mem_rsp_ready = lsu_rsp_ready;
          lsu_rsp_valid = mem_rsp_valid;
          lsu_rsp_rdata = mem_rsp_valid ? mem_rsp_rdata : '0;
        end
        if (mem_rsp_valid && mem_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected
// memory requests and master responses; a negedge monitor pops and compares.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rsp_rdata;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_rsp_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;

  mem_arbiter #(.DATA_LEN(32), .MASK_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mreq_t;

  typedef struct {
    logic        wen;
    logic [31:0] rdata;
  } lrsp_t;

  mreq_t       exp_mreq[$];
  logic [31:0] exp_ifu[$];
  lrsp_t       exp_lsu[$];
  mreq_t       mon_m;
  lrsp_t       mon_l;
  logic [31:0] mon_d;

  int checks = 0;
  int passes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        chk("mreq_expected", 128'(exp_mreq.size() > 0), 128'(1));
        if (exp_mreq.size() > 0) begin
          mon_m = exp_mreq.pop_front();
          chk("mreq_fields",
              128'({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask}),
              128'({mon_m.addr, mon_m.wen, mon_m.wdata, mon_m.wmask}));
        end
      end
      if (ifu_rsp_valid && ifu_rsp_ready) begin
        chk("ifu_rsp_expected", 128'(exp_ifu.size() > 0), 128'(1));
        if (exp_ifu.size() > 0) begin
          mon_d = exp_ifu.pop_front();
          chk("ifu_rsp_rdata", 128'(ifu_rsp_rdata), 128'(mon_d));
        end
      end
      if (lsu_rsp_valid && lsu_rsp_ready) begin
        chk("lsu_rsp_expected", 128'(exp_lsu.size() > 0), 128'(1));
        if (exp_lsu.size() > 0) begin
          mon_l = exp_lsu.pop_front();
          if (!mon_l.wen) chk("lsu_rsp_rdata", 128'(lsu_rsp_rdata), 128'(mon_l.rdata));
        end
      end
    end
  end

  task automatic set_rsp_ready(input bit is_lsu, input logic v);
    if (is_lsu) lsu_rsp_ready = v;
    else ifu_rsp_ready = v;
  endtask

  // Runs one transaction for a master whose request is already being driven.
  task automatic txn(input bit is_lsu, input logic [31:0] addr, input logic wen,
                     input logic [31:0] wdata, input logic [3:0] wmask,
                     input logic [31:0] rdata, input int req_stall, input int rsp_stall);
    mreq_t m;
    lrsp_t l;
    bit    ok;
    m.addr  = addr;
    m.wen   = is_lsu & wen;
    m.wdata = is_lsu ? wdata : 32'h0;
    m.wmask = is_lsu ? wmask : 4'h0;
    exp_mreq.push_back(m);
    if (is_lsu) begin
      l.wen = wen; l.rdata = rdata;
      exp_lsu.push_back(l);
    end else begin
      exp_ifu.push_back(rdata);
    end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (is_lsu ? lsu_req_ready : ifu_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("grant", 128'(ok), 128'(1));
    if (!ok) return;
    chk("grant_exclusive", 128'(is_lsu ? ifu_req_ready : lsu_req_ready), 128'(0));
    @(posedge clk); #1;
    if (is_lsu) lsu_req_valid = 1'b0;
    else ifu_req_valid = 1'b0;

    for (int i = 0; i < req_stall; i++) begin
      @(negedge clk);
      chk("req_stall_hold",
          128'({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask}),
          128'({1'b1, m.addr, m.wen, m.wdata, m.wmask}));
      chk("busy_no_ready", 128'({ifu_req_ready, lsu_req_ready}), 128'(0));
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("req_valid", 128'(mem_req_valid), 128'(1));
    chk("busy_no_ready", 128'({ifu_req_ready, lsu_req_ready}), 128'(0));
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    mem_rsp_rdata = rdata;
    mem_rsp_valid = 1'b0;

    @(negedge clk);
    chk("rsp_gated",
        128'({is_lsu ? lsu_rsp_valid : ifu_rsp_valid, is_lsu ? lsu_rsp_rdata : ifu_rsp_rdata,
              mem_req_valid, mem_rsp_ready, ifu_req_ready, lsu_req_ready}),
        128'(0));
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1;

    for (int i = 0; i < rsp_stall; i++) begin
      @(negedge clk);
      chk("rsp_stall",
          128'({is_lsu ? lsu_rsp_valid : ifu_rsp_valid, mem_rsp_ready,
                is_lsu ? ifu_rsp_valid : lsu_rsp_valid}),
          128'(3'b100));
      @(posedge clk); #1;
    end
    set_rsp_ready(is_lsu, 1'b1);
    @(negedge clk);
    chk("rsp_handshake",
        128'({is_lsu ? lsu_rsp_valid : ifu_rsp_valid, mem_rsp_ready,
              is_lsu ? ifu_rsp_valid : lsu_rsp_valid}),
        128'(3'b110));
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;
    set_rsp_ready(is_lsu, 1'b0);
    chk("back_idle", 128'({mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}), 128'(0));
  endtask

  task automatic set_lsu(input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [3:0] wmask);
    lsu_req_valid = 1'b1;
    lsu_req_addr  = addr;
    lsu_req_wen   = wen;
    lsu_req_wdata = wdata;
    lsu_req_wmask = wmask;
  endtask

  task automatic set_ifu(input logic [31:0] addr);
    ifu_req_valid = 1'b1;
    ifu_req_addr  = addr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got %0d checks expected completion", checks);
    $fatal(1);
  end

  initial begin
    mreq_t m;
    bit    ok;
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_rsp_ready = 1'b0;
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
    lsu_req_wdata = '0; lsu_req_wmask = '0; lsu_rsp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req",
        128'({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask}), 128'(0));
    chk("rst_rsp", 128'({mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}), 128'(0));
    chk("rst_ready", 128'({ifu_req_ready, lsu_req_ready}), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // First tie after reset goes to LSU, then alternates while both stay valid.
    set_ifu(32'h8000_0000);
    set_lsu(32'h8000_1004, 1'b1, 32'hDEAD_BEEF, 4'h3);
    txn(1'b1, 32'h8000_1004, 1'b1, 32'hDEAD_BEEF, 4'h3, 32'h1234_5678, 0, 0);
    set_lsu(32'h8000_1008, 1'b1, 32'h1122_3344, 4'hF);
    txn(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0010_0073, 0, 0);
    set_ifu(32'h8000_0004);
    txn(1'b1, 32'h8000_1008, 1'b1, 32'h1122_3344, 4'hF, 32'h0, 0, 0);
    txn(1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'h0000_0413, 0, 0);

    // Lone IFU read.
    set_ifu(32'h8000_0008);
    txn(1'b0, 32'h8000_0008, 1'b0, 32'h0, 4'h0, 32'h00A0_0513, 0, 0);

    // LSU read under request and response backpressure.
    set_lsu(32'h8000_3000, 1'b0, 32'h0, 4'h0);
    txn(1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D, 5, 3);

    // Reset while an LSU read sits in RSP.
    set_lsu(32'h8000_4000, 1'b0, 32'h0, 4'h0);
    m.addr = 32'h8000_4000; m.wen = 1'b0; m.wdata = 32'h0; m.wmask = 4'h0;
    exp_mreq.push_back(m);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lsu_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("midop_grant", 128'(ok), 128'(1));
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h55AA_55AA;
    @(negedge clk);
    chk("midop_in_rsp", 128'(lsu_rsp_valid), 128'(1));
    rst = 1'b1;
    set_ifu(32'h8000_0100);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;
    chk("midop_rst_outputs",
        128'({mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_addr}), 128'(0));
    set_lsu(32'h8000_4008, 1'b1, 32'h0123_4567, 4'hC);
    txn(1'b1, 32'h8000_4008, 1'b1, 32'h0123_4567, 4'hC, 32'h0, 0, 0);
    txn(1'b0, 32'h8000_0100, 1'b0, 32'h0, 4'h0, 32'h0000_8067, 0, 0);

    repeat (2) @(posedge clk);
    chk("mreq_queue_drained", 128'(exp_mreq.size()), 128'(0));
    chk("ifu_queue_drained", 128'(exp_ifu.size()), 128'(0));
    chk("lsu_queue_drained", 128'(exp_lsu.size()), 128'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
